// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array and its feed sequencer.
package systolic_pkg;

  // PE latency from en_in to a final mac_out value.
  localparam int MAC_LAT = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } feed_state_t;

  // Cycles between the last operand read and all PE accumulators being final.
  function automatic int drain_cycles(input int rd_lat, input int rows, input int cols);
    return rd_lat + rows + cols - 3 + MAC_LAT;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Job, operand-buffer and array-edge bundle of the systolic feed sequencer.
interface systolic_feed_ctrl_if #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int IP_SIZE = 8,
  parameter int K_W     = 10
);
  logic                    start;
  logic [K_W-1:0]          k_len;
  logic                    busy;
  logic                    err;
  logic                    rd_en;
  logic [K_W-1:0]          rd_addr;
  logic [ROWS*IP_SIZE-1:0] x_rd;
  logic [COLS*IP_SIZE-1:0] w_rd;
  logic [ROWS*IP_SIZE-1:0] x_edge;
  logic [COLS*IP_SIZE-1:0] w_edge;
  logic [ROWS-1:0]         en_edge;
  logic [ROWS-1:0]         clr_edge;
  logic                    res_valid;
  logic                    res_ack;

  // Sequencer side.
  modport master (
    input  start, k_len, x_rd, w_rd, res_ack,
    output busy, err, rd_en, rd_addr, x_edge, w_edge, en_edge, clr_edge, res_valid
  );

  // Job issuer, operand buffers, array and result collector side.
  modport slave (
    output start, k_len, x_rd, w_rd, res_ack,
    input  busy, err, rd_en, rd_addr, x_edge, w_edge, en_edge, clr_edge, res_valid
  );
endinterface

// File: rtl/skew_line.sv
// DEPTH-stage register delay line, cleared by reset; DEPTH=0 is a plain wire.
module skew_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [W-1:0] stage_q [DEPTH];

    // NOTE: every stage is cleared on reset so an aborted job leaves no stray en or data in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Tile sequencer: reads K operand vectors, skews them onto the array edges, waits out the drain.
// Optional FEED_PERF_CNT_EN adds busy-cycle and completed-job counters.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int IP_SIZE = 8,
  parameter int K_W     = 10,
  parameter int RD_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_feed_ctrl_if.master bus
`ifdef FEED_PERF_CNT_EN
  ,
  output logic [31:0]          perf_busy_cyc,
  output logic [15:0]          perf_jobs
`endif
);

  localparam int DRAIN_CYC = drain_cycles(RD_LAT, ROWS, COLS);
  localparam int DW        = $clog2(DRAIN_CYC) + 1;

  feed_state_t    state_q, state_d;
  logic [K_W-1:0] k_len_q, k_len_d;
  logic [K_W-1:0] k_cnt_q, k_cnt_d;
  logic [DW-1:0]  dr_cnt_q, dr_cnt_d;
  logic           err_q, err_d;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    k_len_d  = k_len_q;
    k_cnt_d  = k_cnt_q;
    dr_cnt_d = dr_cnt_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.k_len == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = LOAD;
            k_len_d = bus.k_len;
            k_cnt_d = '0;
          end
        end
      end
      LOAD: begin
        if (k_cnt_q == k_len_q - K_W'(1)) begin
          state_d  = DRAIN;
          k_cnt_d  = '0;
          dr_cnt_d = '0;
        end else begin
          k_cnt_d = k_cnt_q + K_W'(1);
        end
      end
      DRAIN: begin
        if (dr_cnt_q == DW'(DRAIN_CYC - 1)) begin
          state_d  = DONE;
          dr_cnt_d = '0;
        end else begin
          dr_cnt_d = dr_cnt_q + DW'(1);
        end
      end
      DONE: begin
        if (bus.res_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_len_q  <= '0;
      k_cnt_q  <= '0;
      dr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_len_q  <= k_len_d;
      k_cnt_q  <= k_cnt_d;
      dr_cnt_q <= dr_cnt_d;
      err_q    <= err_d;
    end
  end

  logic rd_en, rd_clr;
  assign rd_en  = (state_q == LOAD);
  assign rd_clr = rd_en && (k_cnt_q == '0);

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = k_cnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.err       = err_q;

  // Align en/clr with the operand data returned by the buffer.
  logic vld_en, vld_clr;
  skew_line #(.W(2), .DEPTH(RD_LAT)) u_rd_lat (
    .clk (clk),
    .rst (rst),
    .d_i ({rd_en, rd_clr}),
    .q_o ({vld_en, vld_clr})
  );

  logic [IP_SIZE-1:0] x_gated [ROWS];
  logic [IP_SIZE-1:0] w_gated [COLS];
  always_comb begin
    for (int r = 0; r < ROWS; r++)
      x_gated[r] = vld_en ? bus.x_rd[r*IP_SIZE +: IP_SIZE] : '0;
    for (int c = 0; c < COLS; c++)
      w_gated[c] = vld_en ? bus.w_rd[c*IP_SIZE +: IP_SIZE] : '0;
  end

  logic [IP_SIZE+1:0] row_q [ROWS];
  logic [IP_SIZE-1:0] col_q [COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_line #(.W(IP_SIZE + 2), .DEPTH(r)) u_skew (
      .clk (clk),
      .rst (rst),
      .d_i ({vld_en, vld_clr, x_gated[r]}),
      .q_o (row_q[r])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    skew_line #(.W(IP_SIZE), .DEPTH(c)) u_skew (
      .clk (clk),
      .rst (rst),
      .d_i (w_gated[c]),
      .q_o (col_q[c])
    );
  end

  always_comb begin
    bus.en_edge  = '0;
    bus.clr_edge = '0;
    bus.x_edge   = '0;
    bus.w_edge   = '0;
    for (int r = 0; r < ROWS; r++) begin
      bus.en_edge[r]                     = row_q[r][IP_SIZE+1];
      bus.clr_edge[r]                    = row_q[r][IP_SIZE];
      bus.x_edge[r*IP_SIZE +: IP_SIZE]   = row_q[r][IP_SIZE-1:0];
    end
    for (int c = 0; c < COLS; c++)
      bus.w_edge[c*IP_SIZE +: IP_SIZE] = col_q[c];
  end

`ifdef FEED_PERF_CNT_EN
  logic [31:0] perf_busy_cyc_q;
  logic [15:0] perf_jobs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cyc_q <= '0;
      perf_jobs_q     <= '0;
    end else begin
      if (state_q != IDLE) perf_busy_cyc_q <= perf_busy_cyc_q + 32'd1;
      if (state_q == DONE && bus.res_ack) perf_jobs_q <= perf_jobs_q + 16'd1;
    end
  end

  assign perf_busy_cyc = perf_busy_cyc_q;
  assign perf_jobs     = perf_jobs_q;
`endif

endmodule
